// File: rtl/packet_ejector_pkg.sv
// packet_ejector_pkg: shared definitions for the router Local-port ejector.
// Holds the 32-bit packet field layout, ejector FSM state encodings and a
// saturating-counter helper.
package packet_ejector_pkg;

  // Packet layout: {xDst, yDst, xSrc, ySrc, PacketID, ModuleID}
  localparam int XDST_HI  = 31;
  localparam int XDST_LO  = 28;
  localparam int YDST_HI  = 27;
  localparam int YDST_LO  = 24;
  localparam int XSRC_HI  = 23;
  localparam int XSRC_LO  = 20;
  localparam int YSRC_HI  = 19;
  localparam int YSRC_LO  = 16;
  localparam int PKTID_HI = 15;
  localparam int PKTID_LO = 6;
  localparam int MODID_HI = 5;
  localparam int MODID_LO = 0;

  typedef struct packed {
    logic [XDST_HI-XDST_LO:0]   x_dst;
    logic [YDST_HI-YDST_LO:0]   y_dst;
    logic [XSRC_HI-XSRC_LO:0]   x_src;
    logic [YSRC_HI-YSRC_LO:0]   y_src;
    logic [PKTID_HI-PKTID_LO:0] pkt_id;
    logic [MODID_HI-MODID_LO:0] mod_id;
  } pkt_fields_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } ej_state_e;

  // Increment unless already at the ceiling; counters never wrap.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c, input logic en);
    return (en && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

endpackage

// File: rtl/packet_ejector_fifo.sv
// ejector_fifo: synchronous receive FIFO for the packet ejector.
// FIFO_DEPTH must be a power of 2 so the pointers wrap naturally.
// The full flag is registered from the post-update occupancy; a push is
// allowed while full when a pop happens on the same edge.
module ejector_fifo #(
  parameter int dataWidth  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [dataWidth-1:0] din_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [dataWidth-1:0] head_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [dataWidth-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, rd_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 full_q;
  logic                 push_ok, pop_ok;

  assign pop_ok  = pop_i && (cnt_q != '0);
  assign push_ok = push_i && (!full_q || pop_ok);

  // Occupancy next-state from the accepted push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers, occupancy and full flag; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == DEPTH_C);
    end
  end

  // Entry write on accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  assign full_o  = full_q;
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/packet_ejector.sv
// packet_ejector: sink at a router Local output port. Receives packets over
// the req/grant handshake into ejector_fifo, checks destination, optionally
// checks per-source packet-ID sequence, and drains to the PE at a fixed rate.
// Optional feature macro: SEQ_CHECK_EN (per-source sequence checking).
//
// state   | meaning
// IDLE    | waiting for a request; accept if FIFO not full
// GRANT   | grant pulse issued this cycle; drop it
// RELEASE | wait for the request to go low before accepting again
module packet_ejector
  import packet_ejector_pkg::*;
#(
  parameter int             dataWidth      = 32,
  parameter int             dim            = 4,
  parameter logic [dim-1:0] MY_X           = 4'b0_011,
  parameter logic [dim-1:0] MY_Y           = 4'b1_011,
  parameter int             FIFO_DEPTH     = 4,
  parameter int             DRAIN_INTERVAL = 2,
  parameter int             NUM_SRC        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ReqUpStr,
  input  logic [dataWidth-1:0] PacketIn,
  output logic                 GntUpStr,
  output logic                 UpStrFull,
  output logic                 PktValid,
  output logic [dataWidth-1:0] PktData,
  output logic [15:0]          RxCount,
  output logic [15:0]          DstErrCount,
  output logic [15:0]          SeqErrCount
);

  localparam int DW = (DRAIN_INTERVAL > 1) ? $clog2(DRAIN_INTERVAL) : 1;
  localparam logic [DW-1:0] DRAIN_TC = DW'(DRAIN_INTERVAL - 1);

  ej_state_e            state_q;
  logic                 gnt_q;
  logic [DW-1:0]        drain_q, drain_d;
  logic                 valid_q, valid_d;
  logic [dataWidth-1:0] data_q, data_d;
  logic [15:0]          rx_q, rx_d;
  logic [15:0]          dst_q, dst_d;

  logic                 fifo_full, fifo_empty;
  logic [dataWidth-1:0] fifo_head;
  logic                 accept, pop, drain_tc, dst_mismatch;

  assign accept       = (state_q == IDLE) && ReqUpStr && !fifo_full;
  assign drain_tc     = (drain_q == DRAIN_TC);
  assign pop          = drain_tc && !fifo_empty;
  assign dst_mismatch = (PacketIn[XDST_HI -: 2*dim] != {MY_X, MY_Y});

  ejector_fifo #(
    .dataWidth  (dataWidth),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .pop_i   (pop),
    .din_i   (PacketIn),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Handshake FSM with registered grant; RELEASE blocks a held request
  // from being captured twice.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ReqUpStr && !fifo_full) begin
            state_q <= GRANT;
            gnt_q   <= 1'b1;
          end
        end
        GRANT: begin
          state_q <= RELEASE;
          gnt_q   <= 1'b0;
        end
        RELEASE: begin
          if (!ReqUpStr) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 1'b0;
        end
      endcase
    end
  end

  // Next-state for the drain timer, output strobe/data and statistics.
  always_comb begin
    drain_d = drain_tc ? '0 : drain_q + 1'b1;
    valid_d = pop;
    data_d  = pop ? fifo_head : data_q;
    rx_d    = sat_inc16(rx_q, accept);
    dst_d   = sat_inc16(dst_q, accept && dst_mismatch);
  end

  // Drain timer, output registers and statistics counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drain_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      rx_q    <= '0;
      dst_q   <= '0;
    end else begin
      drain_q <= drain_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      rx_q    <= rx_d;
      dst_q   <= dst_d;
    end
  end

`ifdef SEQ_CHECK_EN
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PKTID_HI-PKTID_LO:0] exp_id_q [NUM_SRC];
  logic [SRC_W-1:0]           src_idx;
  logic [PKTID_HI-PKTID_LO:0] pkt_id;
  logic                       seq_err;
  logic [15:0]                seq_q, seq_d;

  assign src_idx = PacketIn[MODID_LO +: SRC_W];
  assign pkt_id  = PacketIn[PKTID_HI:PKTID_LO];
  assign seq_err = accept && (pkt_id != exp_id_q[src_idx]);
  assign seq_d   = sat_inc16(seq_q, seq_err);

  // Expected next ID per source; injectors start numbering at 1, and a gap
  // resynchronises so it is counted only once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) exp_id_q[i] <= 10'd1;
      seq_q <= '0;
    end else begin
      if (accept) exp_id_q[src_idx] <= pkt_id + 10'd1;
      seq_q <= seq_d;
    end
  end

  assign SeqErrCount = seq_q;
`else
  assign SeqErrCount = 16'd0;
`endif

  assign GntUpStr    = gnt_q;
  assign UpStrFull   = fifo_full;
  assign PktValid    = valid_q;
  assign PktData     = data_q;
  assign RxCount     = rx_q;
  assign DstErrCount = dst_q;

endmodule
